// File: rtl/axis_seq_pkg.sv
// Shared types and constants for the AXI4-Stream counter-sequence checker.
package axis_seq_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int unsigned ERR_W            = 4;
  localparam int unsigned ERR_MISMATCH     = 0;
  localparam int unsigned ERR_EARLY_LAST   = 1;
  localparam int unsigned ERR_MISSING_LAST = 2;
  localparam int unsigned ERR_PARTIAL_STRB = 3;

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

  typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/axis_seq_checker_status.sv
// Status block: beat/packet/error counters, sticky flags, first-error capture and lock.
module axis_seq_status
  import axis_seq_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 beat,
  input  logic                 last,
  input  logic                 pkt_good,
  input  err_vec_t             err,
  input  logic [W-1:0]         data,
  output logic [CNT_W-1:0]     beat_count,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output err_vec_t             err_flags,
  output logic [W-1:0]         err_data,
  output logic                 locked
);

  // clr takes priority over a beat accepted in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
      err_flags  <= '0;
      err_data   <= '0;
      locked     <= 1'b0;
    end else if (clr) begin
      beat_count <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
      err_flags  <= '0;
      err_data   <= '0;
      locked     <= 1'b0;
    end else if (beat) begin
      beat_count <= beat_count + CNT_W'(1);
      if (last) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
      if (|err) begin
        if (err_count != ERR_CNT_MAX) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
        if (err_flags == '0) begin
          err_data <= data;
        end
        err_flags <= err_flags | err;
        locked    <= 1'b0;
      end else if (pkt_good) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_seq_checker.sv
// AXI4-Stream slave that checks an incrementing-counter stream beat by beat.
module axis_seq_checker
  import axis_seq_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned C_PKT_LEN            = 8,
  parameter int unsigned C_FIRST_VALUE        = 1,
  parameter int unsigned C_RESTART_PER_PKT    = 1,
  parameter int unsigned C_READY_GAP          = 0
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_aresetn,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                              s_axis_tlast,
  input  logic                              clr,
  output logic [31:0]                       beat_count,
  output logic [31:0]                       pkt_count,
  output logic [15:0]                       err_count,
  output logic [3:0]                        err_flags,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   err_data,
  output logic                              locked
);

  localparam int unsigned W     = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned IDX_W = $clog2(C_PKT_LEN);
  localparam int unsigned GAP_W = (C_READY_GAP > 1) ? $clog2(C_READY_GAP) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_PKT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(C_READY_GAP - 1);
  localparam logic [W-1:0]     FIRST    = W'(C_FIRST_VALUE);

  state_t           state;
  state_t           state_n;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_n;

  logic [W-1:0]     exp;
  logic [IDX_W-1:0] idx;
  logic             pkt_clean;

  logic             accept_c;
  logic             last_idx_c;
  err_vec_t         err_c;
  logic             pkt_good_c;

  assign accept_c   = s_axis_tvalid & s_axis_tready;
  assign last_idx_c = (idx == LAST_IDX);

  // State register; tready is decoded from the next state so it is a flop output
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state         <= S_INIT;
      gap_cnt       <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_n;
      gap_cnt       <= gap_cnt_n;
      s_axis_tready <= (state_n == S_RUN);
    end
  end

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    case (state)
      S_INIT: state_n = S_RUN;
      S_RUN: begin
        if (accept_c && (C_READY_GAP != 0)) begin
          state_n   = S_GAP;
          gap_cnt_n = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = S_RUN;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Per-beat checks against the expected value and packet position
  always_comb begin
    err_c                   = '0;
    err_c[ERR_MISMATCH]     = (s_axis_tdata != exp);
    err_c[ERR_EARLY_LAST]   = s_axis_tlast & ~last_idx_c;
    err_c[ERR_MISSING_LAST] = ~s_axis_tlast & last_idx_c;
    err_c[ERR_PARTIAL_STRB] = (s_axis_tstrb != '1);
  end

  assign pkt_good_c = s_axis_tlast & last_idx_c & pkt_clean & ~(|err_c);

  // Expected value resyncs to tdata+1 every beat; clr never touches this state
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      exp       <= FIRST;
      idx       <= '0;
      pkt_clean <= 1'b1;
    end else if (accept_c) begin
      if (s_axis_tlast && (C_RESTART_PER_PKT != 0)) begin
        exp <= FIRST;
      end else begin
        exp <= s_axis_tdata + W'(1);
      end
      if (s_axis_tlast || last_idx_c) begin
        idx       <= '0;
        pkt_clean <= 1'b1;
      end else begin
        idx <= idx + IDX_W'(1);
        if (|err_c) begin
          pkt_clean <= 1'b0;
        end
      end
    end
  end

  axis_seq_status #(
    .W (W)
  ) u_status (
    .clk        (s_axis_aclk),
    .rst_n      (s_axis_aresetn),
    .clr        (clr),
    .beat       (accept_c),
    .last       (s_axis_tlast),
    .pkt_good   (pkt_good_c),
    .err        (err_c),
    .data       (s_axis_tdata),
    .beat_count (beat_count),
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .err_flags  (err_flags),
    .err_data   (err_data),
    .locked     (locked)
  );

endmodule

// File: tb/tb_axis_seq_checker.sv
// Self-checking bench for axis_seq_checker: directed scenarios, randomized stream, back-pressure.
module tb_axis_seq_checker;

  localparam int unsigned PKT_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid, tready, tlast, clr;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic [31:0] beat_count, pkt_count;
  logic [15:0] err_count;
  logic [3:0]  err_flags;
  logic [63:0] err_data;
  logic        locked;

  logic        g_tvalid, g_tready, g_tlast, g_clr;
  logic [63:0] g_tdata;
  logic [7:0]  g_tstrb;
  logic [31:0] g_beat_count, g_pkt_count;
  logic [15:0] g_err_count;
  logic [3:0]  g_err_flags;
  logic [63:0] g_err_data;
  logic        g_locked;

  always #5 clk = ~clk;

  axis_seq_checker dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .s_axis_tstrb   (tstrb),
    .s_axis_tlast   (tlast),
    .clr            (clr),
    .beat_count     (beat_count),
    .pkt_count      (pkt_count),
    .err_count      (err_count),
    .err_flags      (err_flags),
    .err_data       (err_data),
    .locked         (locked)
  );

  axis_seq_checker #(.C_READY_GAP(2)) dut_gap (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tvalid  (g_tvalid),
    .s_axis_tready  (g_tready),
    .s_axis_tdata   (g_tdata),
    .s_axis_tstrb   (g_tstrb),
    .s_axis_tlast   (g_tlast),
    .clr            (g_clr),
    .beat_count     (g_beat_count),
    .pkt_count      (g_pkt_count),
    .err_count      (g_err_count),
    .err_flags      (g_err_flags),
    .err_data       (g_err_data),
    .locked         (g_locked)
  );

  int compares   = 0;
  int mismatches = 0;

  // Reference model state
  logic [63:0] m_exp;
  int          m_idx;
  logic        m_dirty;
  logic [31:0] m_beats, m_pkts;
  logic [15:0] m_errs;
  logic [3:0]  m_flags;
  logic [63:0] m_err_data;
  logic        m_locked;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compares++;
    assert (obs === expv) else begin
      mismatches++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_beats = 0; m_pkts = 0; m_errs = 0; m_flags = 0; m_err_data = 0; m_locked = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_exp = 64'd1; m_idx = 0; m_dirty = 1'b0;
  endtask

  // One accepted beat, straight from the checking rules
  task automatic model_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic c);
    logic [3:0] e;
    logic       good;
    e = 4'b0000;
    if (d != m_exp) e[0] = 1'b1;
    if (l && m_idx != PKT_LEN - 1) e[1] = 1'b1;
    if (!l && m_idx == PKT_LEN - 1) e[2] = 1'b1;
    if (s != 8'hFF) e[3] = 1'b1;
    if (e != 0) m_dirty = 1'b1;
    good = l && (m_idx == PKT_LEN - 1) && !m_dirty;
    if (c) begin
      model_clear();
    end else begin
      m_beats = m_beats + 1;
      if (l) m_pkts = m_pkts + 1;
      if (e != 0) begin
        if (m_errs != 16'hFFFF) m_errs = m_errs + 1;
        if (m_flags == 0) m_err_data = d;
        m_flags  = m_flags | e;
        m_locked = 1'b0;
      end else if (good) begin
        m_locked = 1'b1;
      end
    end
    m_exp = l ? 64'd1 : d + 64'd1;
    if (l || m_idx == PKT_LEN - 1) begin
      m_idx = 0; m_dirty = 1'b0;
    end else begin
      m_idx = m_idx + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/beats"}, 64'(beat_count), 64'(m_beats));
    check({tag, "/pkts"},  64'(pkt_count),  64'(m_pkts));
    check({tag, "/errs"},  64'(err_count),  64'(m_errs));
    check({tag, "/flags"}, 64'(err_flags),  64'(m_flags));
    check({tag, "/edata"}, err_data,        m_err_data);
    check({tag, "/lock"},  64'(locked),     64'(m_locked));
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge
  task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l, input logic c);
    int n;
    n = 0;
    tvalid = 1'b1; tdata = d; tstrb = s; tlast = l; clr = c;
    while (tready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("tready_timeout", 64'(tready), 64'd1);
    @(posedge clk); #1;
    model_beat(d, s, l, c);
    tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
  endtask

  task automatic send_clean_pkt();
    for (int i = 0; i < PKT_LEN; i++) send(64'(i + 1), 8'hFF, i == PKT_LEN - 1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    tvalid = 0; tdata = 0; tstrb = 8'hFF; tlast = 0; clr = 0;
    g_tvalid = 0; g_tdata = 0; g_tstrb = 8'hFF; g_tlast = 0; g_clr = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/tready", 64'(tready), 64'd0);
    check_all("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel/tready", 64'(tready), 64'd1);

    // Three clean packets
    repeat (3) send_clean_pkt();
    check("clean/pkts", 64'(pkt_count), 64'd3);
    check("clean/beats", 64'(beat_count), 64'd24);
    check("clean/errs", 64'(err_count), 64'd0);
    check("clean/lock", 64'(locked), 64'd1);
    check_all("clean");

    // Corrupted last beat, then a clean packet relocks
    for (int i = 0; i < 7; i++) send(64'(i + 1), 8'hFF, 1'b0, 1'b0);
    send(64'd7, 8'hFF, 1'b1, 1'b0);
    check("corrupt/errs", 64'(err_count), 64'd1);
    check("corrupt/flags", 64'(err_flags), 64'b0001);
    check("corrupt/edata", err_data, 64'd7);
    check("corrupt/lock", 64'(locked), 64'd0);
    send_clean_pkt();
    check("relock/lock", 64'(locked), 64'd1);
    check_all("relock");

    // Partial strobe with simultaneous clr, then a clean packet
    for (int i = 0; i < 7; i++) send(64'(i + 1), 8'hFF, 1'b0, 1'b0);
    send(64'd8, 8'h0F, 1'b1, 1'b1);
    check("strbclr/beats", 64'(beat_count), 64'd0);
    check("strbclr/flags", 64'(err_flags), 64'd0);
    check_all("strbclr");
    send_clean_pkt();
    check("after_clr/beats", 64'(beat_count), 64'd8);
    check_all("after_clr");

    // Length errors: early tlast on beat 5, then 8 beats without tlast
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) send(64'(i + 1), 8'hFF, i == 4, 1'b0);
    for (int i = 0; i < 8; i++) send(64'(i + 1), 8'hFF, 1'b0, 1'b0);
    check("len/flags", 64'(err_flags), 64'b0110);
    check("len/pkts", 64'(pkt_count), 64'd1);
    check("len/errs", 64'(err_count), 64'd2);
    check("len/edata", err_data, 64'd5);
    check_all("len");

    // Asynchronous reset in the middle of a packet
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(64'(i + 1), 8'hFF, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst/tready", 64'(tready), 64'd0);
    check_all("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_clean_pkt();
    check("postrst/errs", 64'(err_count), 64'd0);
    check("postrst/pkts", 64'(pkt_count), 64'd1);
    check_all("postrst");

    // Randomized stream against the model
    for (int b = 0; b < 300; b++) begin
      logic [63:0] d;
      logic [7:0]  s;
      logic        l, c;
      d = m_exp;
      if ($urandom_range(0, 15) == 0) d = {$urandom, $urandom};
      l = (m_idx == PKT_LEN - 1);
      if ($urandom_range(0, 19) == 0) l = ~l;
      s = 8'hFF;
      if ($urandom_range(0, 19) == 0) s = 8'($urandom);
      c = ($urandom_range(0, 49) == 0);
      send(d, s, l, c);
      check_all("rand");
    end

    // Back-pressure: tvalid held high with a 2-cycle ready gap
    begin
      int g_n;
      logic acc;
      g_n = 0;
      g_tvalid = 1'b1; g_tdata = 64'd1; g_tlast = 1'b0;
      for (int i = 0; i < 24; i++) begin
        check("gap/tready", 64'(g_tready), 64'((i % 3) == 0));
        acc = g_tready;
        @(posedge clk); #1;
        if (acc) begin
          g_n++;
          g_tdata = 64'((g_n % PKT_LEN) + 1);
          g_tlast = ((g_n % PKT_LEN) == PKT_LEN - 1);
        end
      end
      g_tvalid = 1'b0;
      check("gap/beats", 64'(g_beat_count), 64'd8);
      check("gap/pkts", 64'(g_pkt_count), 64'd1);
      check("gap/errs", 64'(g_err_count), 64'd0);
      check("gap/lock", 64'(g_locked), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
